// File: rtl/spi_burst_pkg.sv
// Shared types for the SPI burst RAM slave: opcodes, FSM states,
// and the opcode field width.
package spi_burst_pkg;

    localparam int OPC_W = 2;

    typedef enum logic [OPC_W-1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        SHIFT_IN,
        EXEC,
        SHIFT_OUT,
        WAIT
    } state_e;

endpackage

// File: rtl/spi_sp_ram.sv
// Single-port RAM: synchronous write, registered read (1-cycle latency).
// Ports: clk, we/re strobes, addr, wdata in, rdata out.
module spi_sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_burst_ram.sv
// SPI slave endpoint with integrated RAM. Frame = 2-bit opcode + DATA_W
// payload, MSB first. Ports: clk (SCK), rst (sync, high), ss_n, mosi,
// miso (registered), done (execute pulse). Define SPI_BURST_EN to
// auto-increment wr_addr/rd_addr after each data write/read.
module spi_burst_ram
    import spi_burst_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ss_n,
    input  logic mosi,
    output logic miso,
    output logic done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] OPC_LAST = CNT_W'(OPC_W - 1);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [OPC_W-1:0]  opc;
    opcode_e           op;
    logic [DATA_W-1:0] sr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rdata;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic              miso_nxt;
    logic              done_nxt;

    assign op = opcode_e'(opc);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ss_n) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:      state_nxt = OPC;
                OPC:       if (cnt == OPC_LAST) state_nxt = SHIFT_IN;
                SHIFT_IN:  if (cnt == DAT_LAST) state_nxt = EXEC;
                EXEC:      state_nxt = (op == OP_RD_DATA) ? SHIFT_OUT : WAIT;
                SHIFT_OUT: if (cnt == DAT_LAST) state_nxt = WAIT;
                WAIT:      state_nxt = WAIT;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // ss_n high forces every next output to zero and suppresses the
    // RAM write, which is what makes an abort side-effect free.
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = rd_addr;
        miso_nxt = 1'b0;
        done_nxt = 1'b0;
        if (!ss_n) begin
            unique case (1'b1)
                state == EXEC: begin
                    done_nxt = 1'b1;
                    if (op == OP_WR_DATA) begin
                        ram_we   = 1'b1;
                        ram_addr = wr_addr;
                    end
                    if (op == OP_RD_DATA) ram_re = 1'b1;
                end
                state == SHIFT_OUT: begin
                    // First output bit comes straight from the RAM port;
                    // later bits come from the reloaded shift register.
                    miso_nxt = (cnt == '0) ? rdata[DATA_W-1] : sr[DATA_W-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            opc     <= '0;
            sr      <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            miso    <= 1'b0;
            done    <= 1'b0;
        end else begin
            miso <= miso_nxt;
            done <= done_nxt;

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state == OPC || state == SHIFT_IN ||
                         state == SHIFT_OUT) begin
                cnt <= cnt + 1'b1;
            end

            if (!ss_n) begin
                unique case (state)
                    OPC:      opc <= {opc[OPC_W-2:0], mosi};
                    SHIFT_IN: sr  <= {sr[DATA_W-2:0], mosi};
                    EXEC: begin
                        unique case (op)
                            OP_WR_ADDR: wr_addr <= sr[ADDR_W-1:0];
                            OP_RD_ADDR: rd_addr <= sr[ADDR_W-1:0];
                            OP_WR_DATA: if (BURST) wr_addr <= wr_addr + 1'b1;
                            OP_RD_DATA: if (BURST) rd_addr <= rd_addr + 1'b1;
                            default: ;
                        endcase
                    end
                    SHIFT_OUT: begin
                        if (cnt == '0) sr <= {rdata[DATA_W-2:0], 1'b0};
                        else           sr <= {sr[DATA_W-2:0], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_sp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(sr),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_spi_burst_ram.sv
// Scoreboard bench for spi_burst_ram: an 8/8 instance and a 16/4
// instance driven frame by frame, read data checked against a model.
module tb_spi_burst_ram;

`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss8 = 1'b1, mosi8 = 1'b0, miso8, done8;
    logic ss16 = 1'b1, mosi16 = 1'b0, miso16, done16;

    int total = 0;
    int bad = 0;

    logic [15:0] m8 [256];
    logic [15:0] m16 [16];
    int wa [2];
    int ra [2];
    logic [15:0] sbq [$];

    always #5 clk = ~clk;

    spi_burst_ram #(.DATA_W(8), .ADDR_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .ss_n(ss8), .mosi(mosi8),
        .miso(miso8), .done(done8)
    );

    spi_burst_ram #(.DATA_W(16), .ADDR_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .ss_n(ss16), .mosi(mosi16),
        .miso(miso16), .done(done16)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pins(input bit w, input logic s, input logic m);
        if (w) begin ss16 = s; mosi16 = m; end
        else   begin ss8 = s;  mosi8 = m;  end
    endtask

    function automatic logic miso_of(input bit w);
        return w ? miso16 : miso8;
    endfunction

    function automatic logic done_of(input bit w);
        return w ? done16 : done8;
    endfunction

    task automatic model(input bit w, input logic [1:0] op,
                         input logic [15:0] pl);
        int amask = w ? 15 : 255;
        case (op)
            2'b00: wa[w] = int'(pl) & amask;
            2'b01: begin
                if (w) m16[wa[w]] = pl;
                else   m8[wa[w]] = pl & 16'h00FF;
                if (BURST) wa[w] = (wa[w] + 1) & amask;
            end
            2'b10: ra[w] = int'(pl) & amask;
            default: begin
                sbq.push_back(w ? m16[ra[w]] : m8[ra[w]]);
                if (BURST) ra[w] = (ra[w] + 1) & amask;
            end
        endcase
    endtask

    // abort_at < 0: full frame; otherwise raise ss_n after that many
    // payload bits.
    task automatic frame(input bit w, input logic [1:0] op,
                         input logic [15:0] pl, input int abort_at);
        int dw = w ? 16 : 8;
        logic [15:0] obs = '0;
        logic [15:0] exp;
        if (abort_at < 0) model(w, op, pl);
        @(negedge clk); pins(w, 1'b0, 1'b0);
        for (int k = 1; k >= 0; k--) begin
            @(negedge clk); pins(w, 1'b0, op[k]);
        end
        for (int n = 0; n < dw; n++) begin
            if (n == abort_at) begin
                @(negedge clk); pins(w, 1'b1, 1'b0);
                @(negedge clk);
                check("abort_miso", {15'b0, miso_of(w)}, 16'h0);
                check("abort_done", {15'b0, done_of(w)}, 16'h0);
                @(negedge clk);
                return;
            end
            @(negedge clk); pins(w, 1'b0, pl[dw-1-n]);
        end
        @(negedge clk); pins(w, 1'b0, 1'b0);
        check("done_pre", {15'b0, done_of(w)}, 16'h0);
        @(negedge clk);
        check("done_exec", {15'b0, done_of(w)}, 16'h1);
        if (op == 2'b11) begin
            for (int n = 0; n < dw; n++) begin
                @(negedge clk);
                obs = {obs[14:0], miso_of(w)};
            end
            if (sbq.size() == 0) begin
                check("sb_empty", 16'h1, 16'h0);
            end else begin
                exp = sbq.pop_front();
                check("rd_data", obs, exp);
            end
            @(negedge clk);
            check("miso_tail", {15'b0, miso_of(w)}, 16'h0);
        end else begin
            @(negedge clk);
        end
        check("done_once", {15'b0, done_of(w)}, 16'h0);
        pins(w, 1'b1, 1'b0);
        @(negedge clk);
    endtask

    task automatic reset_in_read(input bit w);
        int dw = w ? 16 : 8;
        @(negedge clk); pins(w, 1'b0, 1'b0);
        for (int n = 0; n < 2 + dw; n++) begin
            @(negedge clk); pins(w, 1'b0, n < 2);
        end
        for (int n = 0; n < 5; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_miso", {15'b0, miso_of(w)}, 16'h0);
        check("rst_done", {15'b0, done_of(w)}, 16'h0);
        rst = 1'b0;
        pins(w, 1'b1, 1'b0);
        wa[0] = 0; ra[0] = 0; wa[1] = 0; ra[1] = 0;
        @(negedge clk);
    endtask

    initial begin
        wa[0] = 0; ra[0] = 0; wa[1] = 0; ra[1] = 0;
        repeat (3) @(negedge clk);
        check("init_miso8", {15'b0, miso8}, 16'h0);
        check("init_done8", {15'b0, done8}, 16'h0);
        check("init_miso16", {15'b0, miso16}, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        frame(0, 2'b00, 16'h00, -1);
        frame(0, 2'b01, 16'h5A, -1);

        frame(0, 2'b00, 16'h12, -1);
        frame(0, 2'b01, 16'hA5, -1);
        frame(0, 2'b10, 16'h12, -1);
        frame(0, 2'b11, 16'h00, -1);

        frame(0, 2'b00, 16'h40, -1);
        frame(0, 2'b01, 16'h77, -1);
        frame(0, 2'b00, 16'h40, -1);
        frame(0, 2'b01, 16'h3C, 5);
        frame(0, 2'b10, 16'h40, -1);
        frame(0, 2'b11, 16'h00, -1);
        frame(0, 2'b01, 16'h99, -1);
        frame(0, 2'b10, 16'h40, -1);
        frame(0, 2'b11, 16'h00, -1);

        frame(0, 2'b00, 16'hFF, -1);
        frame(0, 2'b01, 16'hEE, -1);
        frame(0, 2'b00, 16'hFE, -1);
        frame(0, 2'b01, 16'h11, -1);
        frame(0, 2'b01, 16'h22, -1);
        frame(0, 2'b01, 16'h33, -1);
        frame(0, 2'b10, 16'hFE, -1);
        frame(0, 2'b11, 16'h00, -1);
        frame(0, 2'b11, 16'h00, -1);
        frame(0, 2'b11, 16'h00, -1);
        frame(0, 2'b10, 16'hFF, -1);
        frame(0, 2'b11, 16'h00, -1);

        frame(0, 2'b10, 16'hFE, -1);
        reset_in_read(0);
        frame(0, 2'b11, 16'h00, -1);
        frame(0, 2'b01, 16'hC3, -1);
        frame(0, 2'b10, 16'h00, -1);
        frame(0, 2'b11, 16'h00, -1);

        frame(1, 2'b00, 16'hFFF7, -1);
        frame(1, 2'b01, 16'hBEEF, -1);
        frame(1, 2'b00, 16'h0003, -1);
        frame(1, 2'b01, 16'h1234, -1);
        frame(1, 2'b10, 16'hABC7, -1);
        frame(1, 2'b11, 16'h0000, -1);
        frame(1, 2'b10, 16'h0003, -1);
        frame(1, 2'b11, 16'h0000, -1);

        check("sb_drained", 16'(sbq.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
